line_window_buffer: RTL and testbench

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

---
 rtl/edge_detection_pkg.sv | 6 +
 rtl/line_window_buffer_line_ram.sv | 18 +
 rtl/line_window_buffer.sv | 107 ++++++++++
 tb/tb_line_window_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detection_pkg.sv
// edge_detection_pkg: shared pixel type and window-buffer state encoding
package edge_detection_pkg;
  localparam int PIXEL_DEPTH = 24;
  typedef logic [PIXEL_DEPTH-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
endpackage

// File: rtl/line_window_buffer_line_ram.sv
// line_ram: one stored line, single write port and asynchronous read port
module line_ram #(
  parameter int P_COLUMNS     = 640,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [$clog2(P_COLUMNS)-1:0] i_waddr,
  input  logic [P_PIXEL_DEPTH-1:0]     i_wdata,
  input  logic [$clog2(P_COLUMNS)-1:0] i_raddr,
  output logic [P_PIXEL_DEPTH-1:0]     o_rdata
);
  logic [P_PIXEL_DEPTH-1:0] mem [P_COLUMNS];
  assign o_rdata = mem[i_raddr];
  // contents are never reset; a line is always written before it is read
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: vertical P_ROWS-pixel window over raster lines; define LINE_WINDOW_BUFFER_BORDER_REPLICATE_EN to also emit replicated-border columns during fill
module line_window_buffer
  import edge_detection_pkg::*;
#(
  parameter int P_COLUMNS     = 640,
  parameter int P_FRAME_ROWS  = 480,
  parameter int P_ROWS        = 3,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [P_PIXEL_DEPTH-1:0]          i_pixel,
  input  logic                              i_valid,
  input  logic                              i_frame_start,
  output logic                              o_ready,
  output logic [P_ROWS*P_PIXEL_DEPTH-1:0]   o_column_pixels,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(P_COLUMNS)-1:0]      o_column,
  output logic [$clog2(P_FRAME_ROWS)-1:0]   o_row,
  output logic                              o_frame_end
);
  localparam int N  = P_ROWS - 1;
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_FRAME_ROWS);
  localparam int PW = $clog2(P_ROWS);
  localparam logic [CW-1:0] COL_LAST  = CW'(P_COLUMNS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(P_FRAME_ROWS - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(N);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);
  state_t state;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row, row_nxt;
  logic [PW-1:0] ptr, cur_ptr;
  logic acc, fs, active, emit, line_end, frame_last;
  logic [P_PIXEL_DEPTH-1:0] rd [N];
  logic [P_ROWS*P_PIXEL_DEPTH-1:0] window;
  assign o_ready    = !o_valid || i_ready;
  assign acc        = i_valid && o_ready;
  assign fs         = acc && i_frame_start;
  assign active     = acc && (fs || state != IDLE);
  assign cur_col    = fs ? '0 : col;
  assign cur_row    = fs ? '0 : row;
  assign cur_ptr    = fs ? '0 : ptr;
  assign line_end   = cur_col == COL_LAST;
  assign frame_last = line_end && cur_row == ROW_LAST;
  assign row_nxt    = frame_last ? '0 : line_end ? cur_row + 1'b1 : cur_row;
`ifdef LINE_WINDOW_BUFFER_BORDER_REPLICATE_EN
  assign emit = active;
`else
  assign emit = active && cur_row >= ROW_FIRST;
`endif
  // the oldest line's RAM is rewritten by the current line, so pointer ptr always marks the write target
  for (genvar g = 0; g < N; g++) begin : g_line
    line_ram #(
      .P_COLUMNS    (P_COLUMNS),
      .P_PIXEL_DEPTH(P_PIXEL_DEPTH)
    ) u_line_ram (
      .i_clk  (i_clk),
      .i_we   (active && cur_ptr == PW'(g)),
      .i_waddr(cur_col),
      .i_wdata(i_pixel),
      .i_raddr(cur_col),
      .o_rdata(rd[g])
    );
  end
  // slice k takes line row-k, clamped to row 0 so missing lines replicate the oldest received one
  always_comb begin
    window = '0;
    for (int k = 0; k < P_ROWS; k++) begin
      int m, s;
      logic [P_PIXEL_DEPTH-1:0] sel;
      m = (k > int'(cur_row)) ? int'(cur_row) : k;
      s = (int'(cur_ptr) + N - m) % N;
      sel = i_pixel;
      for (int j = 0; j < N; j++) sel = (m != 0 && j == s) ? rd[j] : sel;
      window[k*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = sel;
    end
  end
  // frame position tracking and registered output column with valid/ready hold
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state           <= IDLE;
      col             <= '0;
      row             <= '0;
      ptr             <= '0;
      o_valid         <= 1'b0;
      o_column_pixels <= '0;
      o_column        <= '0;
      o_row           <= '0;
      o_frame_end     <= 1'b0;
    end else begin
      if (active) begin
        col   <= line_end ? '0 : cur_col + 1'b1;
        row   <= row_nxt;
        ptr   <= line_end ? (cur_ptr == PTR_LAST ? '0 : cur_ptr + 1'b1) : cur_ptr;
        state <= frame_last ? IDLE : row_nxt >= ROW_FIRST ? STREAM : FILL;
      end
      if (emit) begin
        o_valid         <= 1'b1;
        o_column_pixels <= window;
        o_column        <= cur_col;
        o_row           <= cur_row;
        o_frame_end     <= frame_last;
      end else if (i_ready) o_valid <= 1'b0;
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: randomized scoreboard bench against a whole-frame image model
module tb_line_window_buffer;
  localparam int C = 8;
  localparam int R = 4;
  localparam int P = 3;
  localparam int D = 8;
`ifdef LINE_WINDOW_BUFFER_BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam int FRAME_OUTS = BORDER ? C*R : C*(R-P+1);
  logic clk = 0, rst_n = 0;
  logic [D-1:0] i_pixel = '0;
  logic i_valid = 0, i_frame_start = 0, i_ready = 1;
  logic o_ready, o_valid, o_frame_end;
  logic [P*D-1:0] o_column_pixels;
  logic [2:0] o_column;
  logic [1:0] o_row;
  always #5 clk = ~clk;
  line_window_buffer #(
    .P_COLUMNS(C), .P_FRAME_ROWS(R), .P_ROWS(P), .P_PIXEL_DEPTH(D)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pixel(i_pixel), .i_valid(i_valid),
    .i_frame_start(i_frame_start), .o_ready(o_ready), .o_column_pixels(o_column_pixels),
    .o_valid(o_valid), .i_ready(i_ready), .o_column(o_column), .o_row(o_row),
    .o_frame_end(o_frame_end)
  );
  typedef struct {
    logic [P*D-1:0] pix;
    int col;
    int row;
    logic fe;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, out_cnt = 0, stall_pct = 0, hold_low = 0;
  logic [D-1:0] img [R][C];
  int mr = 0, mc = 0;
  bit mact = 0;
  logic [P*D-1:0] cap [R][C];
  logic cap_fe [R][C];
  bit prev_stall = 0;
  logic [P*D+5:0] held;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference: keep the frame as an image and read each window column straight out of it
  task automatic model(input logic [D-1:0] p, input logic fs);
    exp_t e;
    if (fs) begin mact = 1; mr = 0; mc = 0; end
    if (!mact) return;
    img[mr][mc] = p;
    if (BORDER || mr >= P-1) begin
      for (int k = 0; k < P; k++) e.pix[k*D +: D] = img[(mr-k < 0) ? 0 : mr-k][mc];
      e.col = mc;
      e.row = mr;
      e.fe = (mr == R-1 && mc == C-1);
      q.push_back(e);
    end
    if (mc == C-1) begin
      mc = 0;
      if (mr == R-1) mact = 0; else mr++;
    end else mc++;
  endtask
  always @(negedge clk) begin
    logic [P*D+5:0] cur;
    exp_t e;
    if (rst_n) begin
      cur = {o_column_pixels, o_column, o_row, o_frame_end};
      chk("o_ready", o_ready, !o_valid || i_ready);
      if (prev_stall) chk("held_output", {cur, o_valid}, {held, 1'b1});
      prev_stall = o_valid && !i_ready;
      held = cur;
      if (o_valid && i_ready) begin
        out_cnt++;
        cap[o_row][o_column] = o_column_pixels;
        cap_fe[o_row][o_column] = o_frame_end;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got row %0d col %0d, required none", o_row, o_column);
        end else begin
          e = q.pop_front();
          chk("pixels", o_column_pixels, e.pix);
          chk("column", o_column, e.col);
          chk("row", o_row, e.row);
          chk("frame_end", o_frame_end, e.fe);
        end
      end
    end else prev_stall = 0;
  end
  function automatic logic pick_ready();
    if (hold_low > 0) begin hold_low--; return 1'b0; end
    return $urandom_range(0, 99) >= stall_pct;
  endfunction
  task automatic cycle();
    i_ready = pick_ready();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [D-1:0] p, input logic fs);
    logic acc;
    int n;
    n = 0;
    acc = 0;
    i_pixel = p;
    i_frame_start = fs;
    i_valid = 1;
    do begin
      i_ready = pick_ready();
      @(negedge clk);
      acc = o_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: o_ready 0 for %0d cycles, required 1", n);
    end else model(p, fs);
    i_valid = 0;
    i_frame_start = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin cycle(); n++; end
    cycle();
    chk("drain_queue_empty", q.size(), 0);
  endtask
  task automatic send_frame(input bit pattern, input bit gaps, input bit stall5);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) cycle();
        send(pattern ? 8'(r*16 + c) : 8'($urandom), r == 0 && c == 0);
        if (stall5 && r == 2 && c == 3) hold_low = 5;
      end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int snap;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_pixels", o_column_pixels, 0);
    chk("reset_column", o_column, 0);
    chk("reset_row", o_row, 0);
    chk("reset_frame_end", o_frame_end, 0);
    chk("reset_ready", o_ready, 1);
    rst_n = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), 0);
      chk("idle_valid", o_valid, 0);
      chk("idle_ready", o_ready, 1);
    end
    snap = out_cnt;
    send_frame(1, 0, 0);
    drain();
    chk("frame1_count", out_cnt - snap, FRAME_OUTS);
    chk("frame1_first", cap[2][0], 24'h001020);
    chk("frame1_last", cap[3][7], 24'h172737);
    chk("frame1_last_fe", cap_fe[3][7], 1);
`ifdef LINE_WINDOW_BUFFER_BORDER_REPLICATE_EN
    chk("border_r0c3", cap[0][3], 24'h030303);
    chk("border_r1c3", cap[1][3], 24'h030313);
`endif
    snap = out_cnt;
    send_frame(1, 0, 1);
    drain();
    chk("stall_frame_count", out_cnt - snap, FRAME_OUTS);
    chk("stall_frame_last", cap[3][7], 24'h172737);
    stall_pct = 40;
    repeat (3) send_frame(0, 1, 0);
    drain();
    stall_pct = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < C; c++)
        if (!(r == 2 && c >= 4)) send(8'(r*16 + c), r == 0 && c == 0);
    drain();
    snap = out_cnt;
    send_frame(1, 0, 0);
    drain();
    chk("resync_count", out_cnt - snap, FRAME_OUTS);
    chk("resync_first", cap[2][0], 24'h001020);
    chk("resync_last", cap[3][7], 24'h172737);
    stall_pct = 30;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (r < 3 || c < 2) send(8'($urandom), r == 0 && c == 0);
    i_pixel = 8'h32;
    i_valid = 1;
    rst_n = 0;
    #1;
    chk("midreset_valid", o_valid, 0);
    chk("midreset_pixels", o_column_pixels, 0);
    chk("midreset_column", o_column, 0);
    chk("midreset_row", o_row, 0);
    chk("midreset_frame_end", o_frame_end, 0);
    q.delete();
    mact = 0;
    @(posedge clk); #1;
    i_valid = 0;
    rst_n = 1;
    stall_pct = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 0);
      chk("post_reset_valid", o_valid, 0);
    end
    stall_pct = 30;
    send_frame(0, 1, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
